// File: rtl/oc_pkg.sv
// Shared types and widths for the dual-channel H-bridge overcurrent monitor.
package oc_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_COOL = 2'd1,
        ST_LOCK = 2'd2
    } oc_state_e;

    localparam int RETRY_W    = 4;
    localparam int TRIP_CNT_W = 8;

endpackage

// File: rtl/oc_channel.sv
// One motor channel: overcurrent debounce, RUN/COOL/LOCK state machine,
// retry bookkeeping and the shared cooldown / healthy-run timer.
module oc_channel
    import oc_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1000,
    parameter int COOLDOWN_CYC = 5_000_000,
    parameter int MAX_RETRY    = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic oc_s,
    input  logic clear_evt,
    input  logic en_req,
    output logic en_out,
    output logic fault,
    output logic lockout,
    output logic trip
);

    localparam int DEB_W = $clog2(DEBOUNCE_CYC + 1);
    localparam int TMR_W = $clog2(COOLDOWN_CYC + 1);
    localparam logic [DEB_W-1:0]   DEB_MAX   = DEB_W'(DEBOUNCE_CYC);
    localparam logic [DEB_W-1:0]   DEB_LAST  = DEB_W'(DEBOUNCE_CYC - 1);
    localparam logic [TMR_W-1:0]   TMR_LAST  = TMR_W'(COOLDOWN_CYC - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

    oc_state_e          state_q, state_d;
    logic [DEB_W-1:0]   deb_q, deb_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [RETRY_W-1:0] retry_q, retry_d;

    // A trip fires once per continuous overcurrent episode, on its Nth cycle.
    assign trip    = oc_s && (deb_q == DEB_LAST);
    assign en_out  = en_req && (state_q == ST_RUN);
    assign fault   = (state_q != ST_RUN);
    assign lockout = (state_q == ST_LOCK);

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        tmr_d   = tmr_q;
        deb_d   = deb_q;

        if (!oc_s) begin
            deb_d = '0;
        end else if (deb_q != DEB_MAX) begin
            deb_d = deb_q + 1'b1;
        end

        case (state_q)
            ST_RUN: begin
                if (trip) begin
                    if (retry_q >= RETRY_MAX) begin
                        state_d = ST_LOCK;
                    end else begin
                        state_d = ST_COOL;
                        retry_d = retry_q + 1'b1;
                        tmr_d   = TMR_LAST;
                    end
                end else begin
                    // In RUN the timer counts healthy cycles up toward the window.
                    if (clear_evt) begin
                        retry_d = '0;
                    end
                    if (tmr_q >= TMR_LAST) begin
                        retry_d = '0;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
            end
            ST_COOL: begin
                if (tmr_q == '0) begin
                    if (oc_s) begin
                        tmr_d = TMR_LAST;
                    end else begin
                        state_d = ST_RUN;
                        tmr_d   = '0;
                    end
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            ST_LOCK: begin
                if (clear_evt && !oc_s) begin
                    state_d = ST_RUN;
                    retry_d = '0;
                    deb_d   = '0;
                    tmr_d   = '0;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            retry_q <= '0;
            tmr_q   <= '0;
            deb_q   <= '0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
            tmr_q   <= tmr_d;
            deb_q   <= deb_d;
        end
    end

endmodule

// File: rtl/oc_monitor.sv
// Dual-channel overcurrent monitor: input synchronizers, operator clear edge
// detection, total trip counter, and two per-channel protection engines.
module oc_monitor
    import oc_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 1000,
    parameter int COOLDOWN_CYC = 5_000_000,
    parameter int MAX_RETRY    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            oc,
    input  logic                  clear,
    input  logic [1:0]            en_req,
    output logic [1:0]            en_out,
    output logic [1:0]            fault,
    output logic [1:0]            lockout,
    output logic [TRIP_CNT_W-1:0] trip_count
);

    logic [1:0]            oc_meta_q, oc_meta_d;
    logic [1:0]            oc_sync_q, oc_sync_d;
    logic                  clear_meta_q, clear_meta_d;
    logic                  clear_sync_q, clear_sync_d;
    logic                  clear_prev_q, clear_prev_d;
    logic [TRIP_CNT_W-1:0] trip_count_q, trip_count_d;

    logic [1:0]            trip;
    logic                  clear_evt;
    logic [TRIP_CNT_W:0]   trip_sum;

    assign clear_evt  = clear_sync_q && !clear_prev_q;
    assign trip_count = trip_count_q;

    always_comb begin
        oc_meta_d    = oc;
        oc_sync_d    = oc_meta_q;
        clear_meta_d = clear;
        clear_sync_d = clear_meta_q;
        clear_prev_d = clear_sync_q;

        // Both channels may trip together, so the increment is 0, 1 or 2.
        trip_sum = {1'b0, trip_count_q}
                 + (TRIP_CNT_W + 1)'(trip[0])
                 + (TRIP_CNT_W + 1)'(trip[1]);
        if (trip_sum[TRIP_CNT_W]) begin
            trip_count_d = '1;
        end else begin
            trip_count_d = trip_sum[TRIP_CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oc_meta_q    <= '0;
            oc_sync_q    <= '0;
            clear_meta_q <= 1'b0;
            clear_sync_q <= 1'b0;
            clear_prev_q <= 1'b0;
            trip_count_q <= '0;
        end else begin
            oc_meta_q    <= oc_meta_d;
            oc_sync_q    <= oc_sync_d;
            clear_meta_q <= clear_meta_d;
            clear_sync_q <= clear_sync_d;
            clear_prev_q <= clear_prev_d;
            trip_count_q <= trip_count_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_chan
            oc_channel #(
                .DEBOUNCE_CYC (DEBOUNCE_CYC),
                .COOLDOWN_CYC (COOLDOWN_CYC),
                .MAX_RETRY    (MAX_RETRY)
            ) u_chan (
                .clk       (clk),
                .rst_n     (rst_n),
                .oc_s      (oc_sync_q[gi]),
                .clear_evt (clear_evt),
                .en_req    (en_req[gi]),
                .en_out    (en_out[gi]),
                .fault     (fault[gi]),
                .lockout   (lockout[gi]),
                .trip      (trip[gi])
            );
        end
    endgenerate

endmodule
